// File: rtl/mul_div_if.sv
// Operation request / result bundle between a requester and mul_div_unit.
// The requester drives start/op/a/b; the unit returns the status and result fields.
interface mul_div_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] zhigh;
    logic [31:0] zlow;
    logic        divz;

    modport master (
        output start, op, a, b,
        input  busy, done, zhigh, zlow, divz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, zhigh, zlow, divz
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative signed 32x32 multiplier (radix-2 Booth) and signed divider (non-restoring on
// magnitudes) sharing one 33+32 bit shift datapath; 32 iterations plus one fix-up cycle.
module mul_div_unit (
    input  logic     clk,
    input  logic     clr,
    mul_div_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_op;
    logic        r_q1;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [31:0] r_m;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic [32:0] r_hi;
    logic        r_busy;
    logic        r_done;
    logic        r_divz;
    logic [31:0] r_zhigh;
    logic [31:0] r_zlow;

    logic [32:0] w_m_ext;
    logic [32:0] w_booth_sum;
    logic [32:0] w_div_sh;
    logic [32:0] w_div_r;
    logic [32:0] w_hi_nx;
    logic [31:0] w_lo_nx;
    logic        w_q1_nx;
    logic [31:0] w_rem_fix;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;
    logic        w_fix_dz;

    function automatic logic [31:0] mag32(input logic [31:0] v);
        mag32 = v[31] ? (32'd0 - v) : v;
    endfunction

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.zhigh = r_zhigh;
    assign bus.zlow  = r_zlow;
    assign bus.divz  = r_divz;

    // One iteration step: Booth add/sub + arithmetic shift, or non-restoring shift/add-sub
    always_comb begin
        w_m_ext = {r_m[31], r_m};
        case ({r_lo[0], r_q1})
            2'b01:   w_booth_sum = r_hi + w_m_ext;
            2'b10:   w_booth_sum = r_hi - w_m_ext;
            default: w_booth_sum = r_hi;
        endcase

        // Quotient bit is the inverted sign of the new partial remainder
        w_div_sh = {r_hi[31:0], r_lo[31]};
        if (r_hi[32]) begin
            w_div_r = w_div_sh + {1'b0, r_m};
        end else begin
            w_div_r = w_div_sh - {1'b0, r_m};
        end

        if (r_op) begin
            w_hi_nx = w_div_r;
            w_lo_nx = {r_lo[30:0], ~w_div_r[32]};
            w_q1_nx = r_q1;
        end else begin
            w_hi_nx = {w_booth_sum[32], w_booth_sum[32:1]};
            w_lo_nx = {w_booth_sum[0], r_lo[31:1]};
            w_q1_nx = r_lo[0];
        end
    end

    // Fix-up: remainder correction, sign restoration, divide-by-zero override
    always_comb begin
        w_rem_fix = r_hi[32] ? (r_hi[31:0] + r_m) : r_hi[31:0];
        if (!r_op) begin
            w_fix_hi = r_hi[31:0];
            w_fix_lo = r_lo;
            w_fix_dz = 1'b0;
        end else if (r_dz) begin
            w_fix_hi = r_a;
            w_fix_lo = 32'hFFFF_FFFF;
            w_fix_dz = 1'b1;
        end else begin
            w_fix_hi = r_neg_r ? (32'd0 - w_rem_fix) : w_rem_fix;
            w_fix_lo = r_neg_q ? (32'd0 - r_lo) : r_lo;
            w_fix_dz = 1'b0;
        end
    end

    // Control FSM with operand capture, iteration registers and registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_cnt   <= 6'd0;
            r_op    <= 1'b0;
            r_q1    <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_m     <= 32'd0;
            r_lo    <= 32'd0;
            r_a     <= 32'd0;
            r_hi    <= 33'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_divz  <= 1'b0;
            r_zhigh <= 32'd0;
            r_zlow  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= 6'd0;
                        r_op    <= bus.op;
                        r_a     <= bus.a;
                        r_q1    <= 1'b0;
                        r_hi    <= 33'd0;
                        if (bus.op) begin
                            r_m     <= mag32(bus.b);
                            r_lo    <= mag32(bus.a);
                            r_neg_q <= bus.a[31] ^ bus.b[31];
                            r_neg_r <= bus.a[31];
                            r_dz    <= (bus.b == 32'd0);
                        end else begin
                            r_m     <= bus.a;
                            r_lo    <= bus.b;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_dz    <= 1'b0;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                RUN: begin
                    // Counter walks 0..31 over the 32 iterations; 32 marks completion
                    if (r_cnt == 6'd32) begin
                        r_state <= FIX;
                    end else begin
                        r_hi  <= w_hi_nx;
                        r_lo  <= w_lo_nx;
                        r_q1  <= w_q1_nx;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                FIX: begin
                    r_zhigh <= w_fix_hi;
                    r_zlow  <= w_fix_lo;
                    r_divz  <= w_fix_dz;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic clr;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    logic [31:0] exp_h;
    logic [31:0] exp_l;
    logic        exp_d;

    mul_div_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done) done_cnt++;

    function automatic void ref_model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] eh, output logic [31:0] el,
                                      output logic ed);
        longint sx, sy, p, q, r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        if (!o) begin
            p  = sx * sy;
            eh = p[63:32];
            el = p[31:0];
            ed = 1'b0;
        end else if (y == 32'd0) begin
            eh = x;
            el = 32'hFFFF_FFFF;
            ed = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            eh = r[31:0];
            el = q[31:0];
            ed = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic chk_result(input string tag);
        chk({tag, ".zhigh"}, 64'(bus.zhigh), 64'(exp_h));
        chk({tag, ".zlow"},  64'(bus.zlow),  64'(exp_l));
        chk({tag, ".divz"},  64'(bus.divz),  64'(exp_d));
    endtask

    task automatic do_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y);
        int lat;
        ref_model(o, x, y, exp_h, exp_l, exp_d);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = ~o; bus.a = $urandom; bus.b = $urandom;
        chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
        wait_done(lat);
        chk({tag, ".lat"}, 64'(lat), 64'd34);
        chk_result(tag);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int lat;
        int d0;
        logic [31:0] x, y;
        logic o;

        clr = 1'b1; bus.start = 1'b0; bus.op = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy",  64'(bus.busy),  64'd0);
        chk("rst.done",  64'(bus.done),  64'd0);
        chk("rst.zhigh", 64'(bus.zhigh), 64'd0);
        chk("rst.zlow",  64'(bus.zlow),  64'd0);
        chk("rst.divz",  64'(bus.divz),  64'd0);
        clr = 1'b0;

        do_op("mul7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("mul7x-3.k", {bus.zhigh, bus.zlow}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("mulmin", 1'b0, 32'h8000_0000, 32'h8000_0000);
        do_op("div-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div-7/2.k", {bus.zhigh, bus.zlow}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("div100/0", 1'b1, 32'd100, 32'd0);
        chk("div100/0.k", {31'd0, bus.divz, bus.zlow}, 64'h1_FFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        chk_result("hold");
        do_op("mulclrdz", 1'b0, 32'd3, 32'd5);
        do_op("divovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf.k", {bus.zhigh, bus.zlow}, 64'h0000_0000_8000_0000);

        // Random mix with biased corner operands
        for (int i = 0; i < 30; i++) begin
            o = 1'($urandom_range(0, 1));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: x = 32'h8000_0000;
                2: y = 32'hFFFF_FFFF;
                3: begin x = $urandom_range(0, 40) - 20; y = $urandom_range(1, 9); end
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), o, x, y);
        end

        // Start re-asserted mid-operation must be ignored
        do_op("pre34", 1'b1, 32'd9, 32'd0);
        ref_model(1'b0, 32'd1234, 32'hFFFF_FF00, exp_h, exp_l, exp_d);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd1234; bus.b = 32'hFFFF_FF00;
        @(posedge clk); #1;
        bus.start = 1'b0;
        d0 = done_cnt;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd77; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("ign.hold", 64'(bus.zhigh), 64'd9);
        wait_done(lat);
        chk("ign.lat", 64'(lat), 64'd29);
        chk_result("ign");
        repeat (40) @(posedge clk);
        #1;
        chk("ign.pulses", 64'(done_cnt - d0), 64'd1);
        chk("ign.busy", 64'(bus.busy), 64'd0);

        // Clear in the middle of an operation
        do_op("preclr", 1'b1, 32'hFFFF_FF00, 32'd0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd11; bus.b = 32'd13;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        d0 = done_cnt;
        chk("clr.busy",  64'(bus.busy),  64'd0);
        chk("clr.zhigh", 64'(bus.zhigh), 64'd0);
        chk("clr.zlow",  64'(bus.zlow),  64'd0);
        chk("clr.divz",  64'(bus.divz),  64'd0);
        repeat (45) @(posedge clk);
        #1;
        chk("clr.nodone", 64'(done_cnt - d0), 64'd0);
        do_op("postclr", 1'b0, 32'hFFFF_FFF0, 32'd3);

        // Clear wins over a simultaneous start
        @(negedge clk);
        bus.start = 1'b1; clr = 1'b1; bus.op = 1'b0; bus.a = 32'd5; bus.b = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0; clr = 1'b0;
        d0 = done_cnt;
        chk("prio.busy", 64'(bus.busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("prio.nodone", 64'(done_cnt - d0), 64'd0);

        // Start held high restarts in the IDLE cycle after DONE
        ref_model(1'b1, 32'd1000, 32'hFFFF_FFF9, exp_h, exp_l, exp_d);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd1000; bus.b = 32'hFFFF_FFF9;
        @(posedge clk); #1;
        wait_done(lat);
        chk("lvl.lat1", 64'(lat), 64'd34);
        chk_result("lvl1");
        @(posedge clk); #1;
        chk("lvl.idle", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        chk("lvl.restart", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_done(lat);
        chk("lvl.lat2", 64'(lat), 64'd34);
        chk_result("lvl2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 1 bit: 0 = signed multiply, 1 = signed divide; captured with start.
REQ-005 SHALL have port a, input, 32 bits: multiplicand or dividend (Y register value); captured with start.
REQ-006 SHALL have port b, input, 32 bits: multiplier or divisor (bus_contents); captured with start.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid; drives Zhigh/Zlow load enables.
REQ-009 SHALL have port zhigh, output, 32 bits: product[63:32] or remainder.
REQ-010 SHALL have port zlow, output, 32 bits: product[31:0] or quotient.
REQ-011 SHALL have port divz, output, 1 bit: set when the last divide had b == 0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-013 SHALL move IDLE->RUN on an edge with start=1, capturing op, a and b; busy=1 from that edge.
REQ-014 SHALL iterate exactly 32 edges in RUN using a 6-bit counter from 0 to 31, then move RUN->FIX.
REQ-015 SHALL use radix-2 Booth recoding in RUN for multiply: 64-bit signed product, two's complement, no overflow.
REQ-016 SHALL use non-restoring division on magnitudes in RUN for divide, with a 33-bit partial remainder.
REQ-017 SHALL perform the following in FIX (1 edge): remainder correction, sign fixes (quotient negated when operand signs differ; remainder takes the dividend's sign), then FIX->DONE.
REQ-018 SHALL, on entering DONE: load zhigh/zlow/divz; assert done=1 and busy=0 for exactly that cycle; then DONE->IDLE.
REQ-019 SHALL set the latency as follows: start sampled at edge E0 gives done high in the cycle after edge E0+34.
REQ-020 SHALL hold zhigh/zlow/divz stable at their previous values except on DONE entry.
REQ-021 SHALL, for a divide with b == 0, produce zlow=0xFFFFFFFF, zhigh=a, divz=1, with the same latency.
REQ-022 SHALL, for a divide of 0x80000000 by 0xFFFFFFFF, produce zlow=0x80000000, zhigh=0, divz=0.
REQ-023 SHALL clear divz on every multiply completion.
REQ-024 SHALL ignore start while busy=1 or in DONE; no queuing, and the captured operands remain unchanged.
REQ-025 SHALL treat start as level-sampled: if start is still high in the IDLE cycle after DONE, it begins a new operation.

Reset
REQ-026 SHALL, on clr=1 at an edge: set state IDLE, busy=0, done=0, zhigh=0, zlow=0, divz=0, counter=0, all internal operand registers 0.
REQ-027 SHALL, on clr mid-operation (RUN/FIX/DONE): abandon the operation, generate no done pulse, and apply the REQ-026 values at that edge.
REQ-028 SHALL give clr priority over start when both are high at the same edge.

Verification
REQ-029 SHALL be verified with op=0, a=7, b=0xFFFFFFFD -> done at E0+34; zhigh=0xFFFFFFFF, zlow=0xFFFFFFEB, divz=0.
REQ-030 SHALL be verified with op=0, a=b=0x80000000 -> zhigh=0x40000000, zlow=0x00000000.
REQ-031 SHALL be verified with op=1, a=0xFFFFFFF9 (-7), b=2 -> zlow=0xFFFFFFFD (-3), zhigh=0xFFFFFFFF (-1); then a=100, b=0 -> zlow=0xFFFFFFFF, zhigh=100, divz=1.
REQ-032 SHALL be verified with op=1, a=0x80000000, b=0xFFFFFFFF -> zlow=0x80000000, zhigh=0.
REQ-033 SHALL be verified as follows: clr pulsed at E0+10 of a multiply -> busy=0 next cycle; no done; outputs 0; a fresh start afterwards completes normally.
REQ-034 SHALL be verified as follows: start re-asserted with different operands at E0+5 -> ignored; the result matches the original operands; done is pulsed exactly once.
